// File: rtl/if_stage_pipeline.sv
// Fetch stage: owns the PC and the IF/ID register and obeys ID's stall/flush/redirect requests; IF/ID lags instr_addr by one edge.
// Stalls hold PC or IF/ID independently and a watchdog flags long pc_stall runs; IF_STAGE_PERF_CNT_EN adds the stall/flush counters.
`timescale 1ns/1ps
module if_stage_pipeline #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 15,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_stall,
  input  logic             IF_ID_stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      instr_rdata,
  output logic [31:0]      instr_addr,
  output logic [31:0]      IF_ID_instr,
  output logic [31:0]      IF_ID_pc4,
  output logic             IF_ID_valid,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              WD_W   = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [31:0]     if_pc4_q, if_pc4_d;
  logic            if_valid_q, if_valid_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            boot;
  logic            stall_eff;
  logic [31:0]     pc_plus4;

  assign boot      = (state_q == BOOT);
  assign stall_eff = pc_stall & ~boot;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = pc_stall ? HOLD : RUN;
      HOLD:    state_d = pc_stall ? HOLD : RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (boot)
      pc_d = RESET_PC + 32'd4;
    else if (pc_stall)
      pc_d = pc_q;
    else if (branch_taken && !IF_ID_stall)
      pc_d = {branch_target[31:2], 2'b00};
    else
      pc_d = pc_plus4;
  end

  // A stalled ID means its branch outcome is not yet valid, so IF_ID_stall outranks the flush.
  always_comb begin
    if_instr_d = if_instr_q;
    if_pc4_d   = if_pc4_q;
    if_valid_d = if_valid_q;
    if (boot || (!IF_ID_stall && !branch_taken)) begin
      if_instr_d = instr_rdata;
      if_pc4_d   = pc_plus4;
      if_valid_d = 1'b1;
    end else if (!IF_ID_stall) begin
      if_instr_d = 32'h0;
      if_pc4_d   = 32'h0;
      if_valid_d = 1'b0;
    end
  end

  always_comb begin
    wd_cnt_d = '0;
    if (stall_eff)
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 1'b1;
    timeout_d = timeout_q | (wd_cnt_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_instr_q <= 32'h0;
      if_pc4_q   <= 32'h0;
      if_valid_q <= 1'b0;
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
      if_valid_q <= if_valid_d;
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign instr_addr    = pc_q;
  assign IF_ID_instr   = if_instr_q;
  assign IF_ID_pc4     = if_pc4_q;
  assign IF_ID_valid   = if_valid_q;
  assign stall_timeout = timeout_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic             flush;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign flush = ~boot & branch_taken & ~IF_ID_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_eff && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
